// File: rtl/soc_system_onchip_ram_dp.sv
// Dual-port on-chip RAM with Avalon-style slave ports, byte lanes,
// optional zero-fill after reset and a counter of same-address dual writes.
// Reads return the word as it was before any write on the same edge; when
// both ports write one address, s1 wins the lanes enabled on both ports.
module soc_system_onchip_ram_dp #(
   parameter int DATA_W         = 16,
   parameter int ADDR_W         = 16,
   parameter int READ_LATENCY   = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [ADDR_W-1:0]      s1_address,
   input  logic                   s1_chipselect,
   input  logic                   s1_read,
   input  logic                   s1_write,
   input  logic [DATA_W/8-1:0]    s1_byteenable,
   input  logic [DATA_W-1:0]      s1_writedata,
   output logic [DATA_W-1:0]      s1_readdata,
   output logic                   s1_readdatavalid,
   output logic                   s1_waitrequest,
   input  logic [ADDR_W-1:0]      s2_address,
   input  logic                   s2_chipselect,
   input  logic                   s2_read,
   input  logic                   s2_write,
   input  logic [DATA_W/8-1:0]    s2_byteenable,
   input  logic [DATA_W-1:0]      s2_writedata,
   output logic [DATA_W-1:0]      s2_readdata,
   output logic                   s2_readdatavalid,
   output logic                   s2_waitrequest,
   output logic                   clear_busy,
   output logic [15:0]            collision_count
);

   localparam int BE_W  = DATA_W / 8;
   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   clr_cnt_q;
   logic [15:0]         coll_cnt_q;
   logic [15:0]         coll_cnt_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   logic                run_s;
   logic                clr_we_s;
   logic                s1_wr_acc_s;
   logic                s1_rd_acc_s;
   logic                s2_wr_acc_s;
   logic                s2_rd_acc_s;
   logic                coll_hit_s;
   logic [DATA_W-1:0]   s1_rdword_s;
   logic [DATA_W-1:0]   s2_rdword_s;
   logic                s1_pipe_vld_s;
   logic                s2_pipe_vld_s;
   logic [DATA_W-1:0]   s1_pipe_dat_s;
   logic [DATA_W-1:0]   s2_pipe_dat_s;
   logic [DATA_W-1:0]   s1_readdata_q;
   logic [DATA_W-1:0]   s2_readdata_q;
   logic                s1_rdv_q;
   logic                s2_rdv_q;

   // Stall follows reset_n directly so masters see it even in the reset cycle.
   assign run_s          = reset_n && (state_q == ST_RUN);
   assign clr_we_s       = reset_n && (state_q == ST_CLEAR);
   assign s1_waitrequest = ~run_s;
   assign s2_waitrequest = ~run_s;
   assign clear_busy     = clr_we_s;

   // A simultaneous write wins over a read on the same port.
   assign s1_wr_acc_s = s1_chipselect & s1_write & run_s;
   assign s1_rd_acc_s = s1_chipselect & s1_read & ~s1_write & run_s;
   assign s2_wr_acc_s = s2_chipselect & s2_write & run_s;
   assign s2_rd_acc_s = s2_chipselect & s2_read & ~s2_write & run_s;
   assign coll_hit_s  = s1_wr_acc_s & s2_wr_acc_s & (s1_address == s2_address);

   assign s1_rdword_s = mem_q[s1_address];
   assign s2_rdword_s = mem_q[s2_address];

   assign s1_readdata      = s1_readdata_q;
   assign s2_readdata      = s2_readdata_q;
   assign s1_readdatavalid = s1_rdv_q;
   assign s2_readdatavalid = s2_rdv_q;
   assign collision_count  = coll_cnt_q;

   // Saturating next value of the dual-write collision counter.
   always_comb begin
      coll_cnt_d = coll_cnt_q;
      if (coll_hit_s && (coll_cnt_q != 16'hFFFF)) begin
         coll_cnt_d = coll_cnt_q + 16'd1;
      end else begin
         coll_cnt_d = coll_cnt_q;
      end
   end

   // Control FSM: zero-fill sweep after reset, then normal operation.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
         clr_cnt_q  <= '0;
         coll_cnt_q <= 16'd0;
      end else begin
         coll_cnt_q <= coll_cnt_d;
         case (state_q)
            ST_CLEAR: begin
               if (clr_cnt_q == {ADDR_W{1'b1}}) begin
                  clr_cnt_q <= '0;
                  state_q   <= ST_RUN;
               end else begin
                  clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
               end
            end
            ST_RUN: begin
               state_q <= ST_RUN;
            end
            default: begin
               state_q   <= ST_CLEAR;
               clr_cnt_q <= '0;
            end
         endcase
      end
   end

   // Storage array; s1 lanes are applied last so they win on overlap. Not reset.
   always_ff @(posedge clk) begin
      if (clr_we_s) begin
         mem_q[clr_cnt_q] <= '0;
      end else begin
         for (int i = 0; i < BE_W; i++) begin
            if (s2_wr_acc_s && s2_byteenable[i]) begin
               mem_q[s2_address][8*i +: 8] <= s2_writedata[8*i +: 8];
            end
            if (s1_wr_acc_s && s1_byteenable[i]) begin
               mem_q[s1_address][8*i +: 8] <= s1_writedata[8*i +: 8];
            end
         end
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic              s1_p_vld_q;
         logic              s2_p_vld_q;
         logic [DATA_W-1:0] s1_p_dat_q;
         logic [DATA_W-1:0] s2_p_dat_q;

         // Extra read stage holding the fetched word one more cycle.
         always_ff @(posedge clk) begin
            if (!reset_n) begin
               s1_p_vld_q <= 1'b0;
               s2_p_vld_q <= 1'b0;
               s1_p_dat_q <= '0;
               s2_p_dat_q <= '0;
            end else begin
               s1_p_vld_q <= s1_rd_acc_s;
               s2_p_vld_q <= s2_rd_acc_s;
               if (s1_rd_acc_s) begin
                  s1_p_dat_q <= s1_rdword_s;
               end
               if (s2_rd_acc_s) begin
                  s2_p_dat_q <= s2_rdword_s;
               end
            end
         end

         assign s1_pipe_vld_s = s1_p_vld_q;
         assign s2_pipe_vld_s = s2_p_vld_q;
         assign s1_pipe_dat_s = s1_p_dat_q;
         assign s2_pipe_dat_s = s2_p_dat_q;
      end else begin : g_lat1
         assign s1_pipe_vld_s = s1_rd_acc_s;
         assign s2_pipe_vld_s = s2_rd_acc_s;
         assign s1_pipe_dat_s = s1_rdword_s;
         assign s2_pipe_dat_s = s2_rdword_s;
      end
   endgenerate

   // Output registers: valid pulses for one cycle, data holds between pulses.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1_rdv_q      <= 1'b0;
         s2_rdv_q      <= 1'b0;
         s1_readdata_q <= '0;
         s2_readdata_q <= '0;
      end else begin
         s1_rdv_q <= s1_pipe_vld_s;
         s2_rdv_q <= s2_pipe_vld_s;
         if (s1_pipe_vld_s) begin
            s1_readdata_q <= s1_pipe_dat_s;
         end
         if (s2_pipe_vld_s) begin
            s2_readdata_q <= s2_pipe_dat_s;
         end
      end
   end

endmodule

// File: tb/tb_soc_system_onchip_ram_dp.sv
// Bench for soc_system_onchip_ram_dp: two instances (read latency 1 and 2)
// share one stimulus stream and are checked every cycle against a word-level
// reference model, plus a table of directed vectors and reset sequences.
module tb_soc_system_onchip_ram_dp;

   localparam int DW    = 16;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                          reset_n;
   logic [1:0]                    cs, rd, wr;
   logic [1:0][AW-1:0]            addr;
   logic [1:0][1:0]               be;
   logic [1:0][DW-1:0]            wd;
   logic [1:0][1:0][DW-1:0]       rdata;
   logic [1:0][1:0]               rdv, wrq;
   logic [1:0]                    busy;
   logic [1:0][15:0]              coll;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      soc_system_onchip_ram_dp #(
         .DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(g + 1), .CLEAR_ON_RESET(1)
      ) u_dut (
         .clk(clk), .reset_n(reset_n),
         .s1_address(addr[0]), .s1_chipselect(cs[0]), .s1_read(rd[0]), .s1_write(wr[0]),
         .s1_byteenable(be[0]), .s1_writedata(wd[0]), .s1_readdata(rdata[g][0]),
         .s1_readdatavalid(rdv[g][0]), .s1_waitrequest(wrq[g][0]),
         .s2_address(addr[1]), .s2_chipselect(cs[1]), .s2_read(rd[1]), .s2_write(wr[1]),
         .s2_byteenable(be[1]), .s2_writedata(wd[1]), .s2_readdata(rdata[g][1]),
         .s2_readdatavalid(rdv[g][1]), .s2_waitrequest(wrq[g][1]),
         .clear_busy(busy[g]), .collision_count(coll[g])
      );
   end

   // Reference model state
   logic [DW-1:0] m_mem [DEPTH];
   bit            m_clear;
   int            m_caddr;
   int            m_coll;
   bit            l1_v [2];
   logic [DW-1:0] l1_d [2];
   bit            st_v [2];
   logic [DW-1:0] st_d [2];
   bit            l2_v [2];
   logic [DW-1:0] l2_d [2];

   int checks = 0;
   int errors = 0;
   int pulses [2][2];

   task automatic chk(input string nm, input int d, input int p,
                      input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s dut%0d port%0d: got %h expected %h", nm, d, p, got, exp);
      end
   endtask

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_step();
      bit            wa [2];
      bit            ra [2];
      logic [DW-1:0] rw [2];
      if (!reset_n) begin
         m_clear = 1'b1;
         m_caddr = 0;
         m_coll  = 0;
         for (int p = 0; p < 2; p++) begin
            l1_v[p] = 1'b0; l1_d[p] = '0;
            st_v[p] = 1'b0; st_d[p] = '0;
            l2_v[p] = 1'b0; l2_d[p] = '0;
         end
      end else begin
         for (int p = 0; p < 2; p++) begin
            wa[p] = cs[p] && wr[p] && !m_clear;
            ra[p] = cs[p] && rd[p] && !wr[p] && !m_clear;
            rw[p] = m_mem[addr[p]];
            l2_v[p] = st_v[p];
            if (st_v[p]) l2_d[p] = st_d[p];
            st_v[p] = ra[p];
            if (ra[p]) st_d[p] = rw[p];
            l1_v[p] = ra[p];
            if (ra[p]) l1_d[p] = rw[p];
         end
         if (m_clear) begin
            m_mem[m_caddr] = '0;
            if (m_caddr == DEPTH - 1) begin
               m_clear = 1'b0;
               m_caddr = 0;
            end else begin
               m_caddr++;
            end
         end else begin
            if (wa[0] && wa[1] && addr[0] == addr[1] && m_coll < 65535) m_coll++;
            for (int l = 0; l < DW / 8; l++) begin
               // s1 has priority on a lane both ports enable at one address
               if (wa[1] && be[1][l] && !(wa[0] && be[0][l] && addr[0] == addr[1]))
                  m_mem[addr[1]][8*l +: 8] = wd[1][8*l +: 8];
               if (wa[0] && be[0][l])
                  m_mem[addr[0]][8*l +: 8] = wd[0][8*l +: 8];
            end
         end
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         for (int p = 0; p < 2; p++) begin
            chk("readdatavalid", d, p, 32'(rdv[d][p]), (d == 0) ? 32'(l1_v[p]) : 32'(l2_v[p]));
            chk("readdata", d, p, 32'(rdata[d][p]), (d == 0) ? 32'(l1_d[p]) : 32'(l2_d[p]));
            chk("waitrequest", d, p, 32'(wrq[d][p]), 32'(!reset_n || m_clear));
            if (rdv[d][p] === 1'b1) pulses[d][p]++;
         end
         chk("clear_busy", d, 0, 32'(busy[d]), 32'(reset_n && m_clear));
         chk("collision_count", d, 0, 32'(coll[d]), 32'(m_coll));
      end
   endtask

   task automatic idle();
      cs = 2'b00; rd = 2'b00; wr = 2'b00;
      addr = '0; be = '0; wd = '0;
   endtask

   task automatic clr_pulses();
      for (int d = 0; d < 2; d++)
         for (int p = 0; p < 2; p++) pulses[d][p] = 0;
   endtask

   // Release reset and count the cycles clear_busy stays high.
   task automatic release_and_count(input string nm);
      int n;
      reset_n = 1'b1;
      #1;
      n = 0;
      while (busy[0] === 1'b1 && n < 40) begin
         n++;
         tick();
      end
      chk(nm, 0, 0, 32'(n), 32'd16);
   endtask

   typedef struct {
      logic [1:0]          cs, rd, wr;
      logic [1:0][AW-1:0]  a;
      logic [1:0][1:0]     be;
      logic [1:0][DW-1:0]  wd;
      logic                ev1;
      logic [DW-1:0]       ed1;
      logic                ev2;
      logic [DW-1:0]       ed2;
      logic [15:0]         ec;
   } vec_t;

   function automatic vec_t mk(
      input logic c1, r1, w1, input logic [AW-1:0] a1, input logic [1:0] b1, input logic [DW-1:0] d1,
      input logic c2, r2, w2, input logic [AW-1:0] a2, input logic [1:0] b2, input logic [DW-1:0] d2,
      input logic ev1, input logic [DW-1:0] ed1, input logic ev2, input logic [DW-1:0] ed2,
      input logic [15:0] ec);
      vec_t v;
      v.cs = {c2, c1}; v.rd = {r2, r1}; v.wr = {w2, w1};
      v.a[0] = a1; v.a[1] = a2; v.be[0] = b1; v.be[1] = b2; v.wd[0] = d1; v.wd[1] = d2;
      v.ev1 = ev1; v.ed1 = ed1; v.ev2 = ev2; v.ed2 = ed2; v.ec = ec;
      return v;
   endfunction

   vec_t tbl [12];

   initial begin
      // s2 expectations: ev1/ed1 for latency 1, ev2/ed2 for latency 2
      tbl[0]  = mk(1'b1,1'b0,1'b1,4'd3,2'b11,16'hABCD, 1'b0,1'b0,1'b0,4'd0,2'b00,16'h0000, 1'b0,16'h0000, 1'b0,16'h0000, 16'd0);
      tbl[1]  = mk(1'b1,1'b0,1'b1,4'd3,2'b01,16'h1234, 1'b0,1'b0,1'b0,4'd0,2'b00,16'h0000, 1'b0,16'h0000, 1'b0,16'h0000, 16'd0);
      tbl[2]  = mk(1'b0,1'b0,1'b0,4'd0,2'b00,16'h0000, 1'b1,1'b1,1'b0,4'd3,2'b11,16'h0000, 1'b1,16'hAB34, 1'b0,16'h0000, 16'd0);
      tbl[3]  = mk(1'b1,1'b0,1'b1,4'd5,2'b11,16'h1111, 1'b1,1'b0,1'b1,4'd5,2'b10,16'h2222, 1'b0,16'hAB34, 1'b1,16'hAB34, 16'd1);
      tbl[4]  = mk(1'b0,1'b0,1'b0,4'd0,2'b00,16'h0000, 1'b1,1'b1,1'b0,4'd5,2'b11,16'h0000, 1'b1,16'h1111, 1'b0,16'hAB34, 16'd1);
      tbl[5]  = mk(1'b1,1'b0,1'b1,4'd5,2'b01,16'h1111, 1'b1,1'b0,1'b1,4'd5,2'b10,16'h2222, 1'b0,16'h1111, 1'b1,16'h1111, 16'd2);
      tbl[6]  = mk(1'b0,1'b0,1'b0,4'd0,2'b00,16'h0000, 1'b1,1'b1,1'b0,4'd5,2'b11,16'h0000, 1'b1,16'h2211, 1'b0,16'h1111, 16'd2);
      tbl[7]  = mk(1'b1,1'b0,1'b1,4'd7,2'b11,16'hBEEF, 1'b1,1'b1,1'b0,4'd7,2'b11,16'h0000, 1'b1,16'h0000, 1'b1,16'h2211, 16'd2);
      tbl[8]  = mk(1'b0,1'b0,1'b0,4'd0,2'b00,16'h0000, 1'b1,1'b1,1'b0,4'd7,2'b11,16'h0000, 1'b1,16'hBEEF, 1'b1,16'h0000, 16'd2);
      tbl[9]  = mk(1'b0,1'b0,1'b0,4'd0,2'b00,16'h0000, 1'b0,1'b0,1'b0,4'd0,2'b00,16'h0000, 1'b0,16'hBEEF, 1'b1,16'hBEEF, 16'd2);
      tbl[10] = mk(1'b0,1'b0,1'b0,4'd0,2'b00,16'h0000, 1'b1,1'b1,1'b1,4'd7,2'b11,16'h5555, 1'b0,16'hBEEF, 1'b0,16'hBEEF, 16'd2);
      tbl[11] = mk(1'b0,1'b0,1'b0,4'd0,2'b00,16'h0000, 1'b1,1'b1,1'b0,4'd7,2'b00,16'h0000, 1'b1,16'h5555, 1'b0,16'hBEEF, 16'd2);

      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      clr_pulses();
      reset_n = 1'b0;
      idle();
      @(negedge clk);

      // Reset state, then zero-fill length and contents
      repeat (3) tick();
      release_and_count("clear_cycles");
      for (int i = 0; i < DEPTH; i++) begin
         cs = 2'b11; rd = 2'b11; wr = 2'b00;
         addr[0] = AW'(i); addr[1] = AW'(DEPTH - 1 - i);
         tick();
      end
      idle();
      repeat (2) tick();

      // Directed vectors
      for (int i = 0; i < 12; i++) begin
         cs = tbl[i].cs; rd = tbl[i].rd; wr = tbl[i].wr;
         addr = tbl[i].a; be = tbl[i].be; wd = tbl[i].wd;
         tick();
         chk("tbl_valid_lat1", 0, 1, 32'(rdv[0][1]), 32'(tbl[i].ev1));
         chk("tbl_data_lat1", 0, 1, 32'(rdata[0][1]), 32'(tbl[i].ed1));
         chk("tbl_valid_lat2", 1, 1, 32'(rdv[1][1]), 32'(tbl[i].ev2));
         chk("tbl_data_lat2", 1, 1, 32'(rdata[1][1]), 32'(tbl[i].ed2));
         chk("tbl_collisions", 0, 0, 32'(coll[0]), 32'(tbl[i].ec));
      end
      idle();
      repeat (2) tick();

      // Back-to-back reads on both ports for 8 cycles
      clr_pulses();
      for (int i = 0; i < 8; i++) begin
         cs = 2'b11; rd = 2'b11; wr = 2'b00;
         addr[0] = AW'(i); addr[1] = AW'(i + 8);
         tick();
      end
      idle();
      repeat (3) tick();
      for (int d = 0; d < 2; d++)
         for (int p = 0; p < 2; p++) chk("b2b_pulses", d, p, 32'(pulses[d][p]), 32'd8);

      // Read in flight, reset, then reset again mid-clear at address 9
      cs = 2'b01; rd = 2'b01; wr = 2'b00; addr[0] = 4'd3;
      tick();
      idle();
      clr_pulses();
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      repeat (9) tick();
      chk("clear_busy_mid", 0, 0, 32'(busy[0]), 32'd1);
      reset_n = 1'b0;
      tick();
      release_and_count("clear_restart_cycles");
      for (int d = 0; d < 2; d++) chk("inflight_discard", d, 0, 32'(pulses[d][0]), 32'd0);

      // Randomized traffic with frequent address clashes
      for (int i = 0; i < 600; i++) begin
         for (int p = 0; p < 2; p++) begin
            cs[p]   = ($urandom_range(0, 3) != 0);
            rd[p]   = 1'($urandom);
            wr[p]   = 1'($urandom);
            addr[p] = AW'($urandom_range(0, DEPTH - 1));
            be[p]   = 2'($urandom);
            wd[p]   = DW'($urandom);
         end
         if ($urandom_range(0, 3) == 0) addr[1] = addr[0];
         tick();
      end
      idle();
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
